// File: rtl/ddr4_ui_pkg.sv
// Shared DDR4 UI constants: command encodings, BL8 address stride and the
// backpressure LFSR seed/taps, plus the LFSR step function.
package ddr4_ui_pkg;

  localparam logic [2:0]  UI_CMD_WRITE  = 3'b000;
  localparam logic [2:0]  UI_CMD_READ   = 3'b001;
  localparam int          UI_BL8_STRIDE = 8;
  localparam logic [15:0] UI_LFSR_SEED  = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] UI_LFSR_TAPS  = 16'hB400;

  function automatic logic [15:0] lfsr16_next(input logic [15:0] state);
    logic fb;
    fb = ^(state & UI_LFSR_TAPS);
    return {state[14:0], fb};
  endfunction

endpackage

// File: rtl/ui_sync_fifo.sv
// Single-clock FIFO used for the UI command and write-data queues.
// Push is ignored when full and pop is ignored when empty.
module ui_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] store_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      store_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = store_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == '0);
  assign count = count_r;

endmodule

// File: rtl/ddr4_ui_responder.sv
// Behavioural memory-side responder for the DDR4 MIG user interface, backed by an internal RAM.
// Optional macro UI_BACKPRESSURE_EN gates the readies with a free-running LFSR.
module ddr4_ui_responder
  import ddr4_ui_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 256,
  parameter int MEM_AW     = 10,
  parameter int RD_LATENCY = 4,
  parameter int Q_DEPTH    = 4,
  parameter int CALIB_CYC  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  calib_done,
  input  logic                  app_en,
  input  logic [2:0]            app_cmd,
  input  logic [ADDR_W-1:0]     app_addr,
  output logic                  app_rdy,
  input  logic                  app_wdf_wren,
  input  logic [DATA_W-1:0]     app_wdf_data,
  input  logic                  app_wdf_end,
  input  logic [DATA_W/8-1:0]   app_wdf_mask,
  output logic                  app_wdf_rdy,
  output logic [DATA_W-1:0]     app_rd_data,
  output logic                  app_rd_data_valid,
  output logic                  app_rd_data_end,
  output logic                  err_cmd,
  output logic [31:0]           wr_done_cnt,
  output logic [31:0]           rd_done_cnt
);

  localparam int MASK_W    = DATA_W / 8;
  localparam int CMDQ_W    = 3 + ADDR_W;
  localparam int WDFQ_W    = DATA_W + MASK_W + 1;
  localparam int QC_W      = $clog2(Q_DEPTH) + 1;
  localparam int CAL_W     = $clog2(CALIB_CYC + 1);
  localparam int MEM_DEPTH = 1 << MEM_AW;

  logic                calib_done_r;
  logic [CAL_W-1:0]    cal_cnt_r;
  logic                err_cmd_r;
  logic [31:0]         wr_cnt_r;
  logic [31:0]         rd_cnt_r;

  logic                cmd_gate_s;
  logic                wdf_gate_s;
  logic                cmd_push_s;
  logic                wdf_push_s;
  logic                cmd_pop_s;
  logic                wdf_pop_s;
  logic                mem_we_s;
  logic                rd_exec_s;
  logic                ill_exec_s;

  logic [CMDQ_W-1:0]   cmdq_dout_s;
  logic                cmdq_full_s;
  logic                cmdq_empty_s;
  logic [QC_W-1:0]     cmdq_count_s;
  logic [WDFQ_W-1:0]   wdfq_dout_s;
  logic                wdfq_full_s;
  logic                wdfq_empty_s;
  logic [QC_W-1:0]     wdfq_count_s;

  logic [2:0]          head_cmd_s;
  logic [MEM_AW-1:0]   head_idx_s;
  logic [DATA_W-1:0]   head_data_s;
  logic [MASK_W-1:0]   head_mask_s;

  logic [DATA_W-1:0]   mem_r [MEM_DEPTH];
  logic [RD_LATENCY-1:0] vpipe_r;
  logic [DATA_W-1:0]   dpipe_r [RD_LATENCY];
  logic                unused_s;

`ifdef UI_BACKPRESSURE_EN
  logic [15:0] lfsr_r;

  // Free-running LFSR that randomly withholds the readies
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_r <= UI_LFSR_SEED;
    end else begin
      lfsr_r <= lfsr16_next(lfsr_r);
    end
  end

  assign cmd_gate_s = lfsr_r[0];
  assign wdf_gate_s = lfsr_r[1];
`else
  assign cmd_gate_s = 1'b1;
  assign wdf_gate_s = 1'b1;
`endif

  // Readies depend on registered state only, so a same-cycle pop never frees a full queue
  assign app_rdy     = calib_done_r & ~cmdq_full_s & cmd_gate_s;
  assign app_wdf_rdy = calib_done_r & ~wdfq_full_s & wdf_gate_s;
  assign cmd_push_s  = app_en & app_rdy;
  assign wdf_push_s  = app_wdf_wren & app_wdf_rdy;

  ui_sync_fifo #(
    .WIDTH (CMDQ_W),
    .DEPTH (Q_DEPTH)
  ) u_cmdq (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cmd_push_s),
    .din     ({app_cmd, app_addr}),
    .pop     (cmd_pop_s),
    .dout    (cmdq_dout_s),
    .full    (cmdq_full_s),
    .empty   (cmdq_empty_s),
    .count   (cmdq_count_s)
  );

  ui_sync_fifo #(
    .WIDTH (WDFQ_W),
    .DEPTH (Q_DEPTH)
  ) u_wdfq (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wdf_push_s),
    .din     ({app_wdf_end, app_wdf_mask, app_wdf_data}),
    .pop     (wdf_pop_s),
    .dout    (wdfq_dout_s),
    .full    (wdfq_full_s),
    .empty   (wdfq_empty_s),
    .count   (wdfq_count_s)
  );

  assign head_cmd_s  = cmdq_dout_s[ADDR_W +: 3];
  assign head_idx_s  = cmdq_dout_s[3 +: MEM_AW];
  assign head_data_s = wdfq_dout_s[DATA_W-1:0];
  assign head_mask_s = wdfq_dout_s[DATA_W +: MASK_W];

  assign unused_s = ^{cmdq_count_s, wdfq_count_s, wdfq_dout_s[WDFQ_W-1],
                      cmdq_dout_s[2:0], cmdq_dout_s[ADDR_W-1:3+MEM_AW]};

  // Execute stage: retire at most one command per cycle from the cmdq head
  always_comb begin
    cmd_pop_s  = 1'b0;
    wdf_pop_s  = 1'b0;
    mem_we_s   = 1'b0;
    rd_exec_s  = 1'b0;
    ill_exec_s = 1'b0;
    if (!cmdq_empty_s) begin
      case (head_cmd_s)
        UI_CMD_WRITE: begin
          if (!wdfq_empty_s) begin
            cmd_pop_s = 1'b1;
            wdf_pop_s = 1'b1;
            mem_we_s  = 1'b1;
          end else begin
            cmd_pop_s = 1'b0;
          end
        end
        UI_CMD_READ: begin
          cmd_pop_s = 1'b1;
          rd_exec_s = 1'b1;
        end
        default: begin
          cmd_pop_s  = 1'b1;
          ill_exec_s = 1'b1;
        end
      endcase
    end else begin
      cmd_pop_s = 1'b0;
    end
  end

  // Byte-masked RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!head_mask_s[b]) begin
          mem_r[head_idx_s][b*8 +: 8] <= head_data_s[b*8 +: 8];
        end
      end
    end
  end

  // Registered RAM read followed by a fixed-length return pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vpipe_r  <= '0;
      rd_cnt_r <= 32'd0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        dpipe_r[i] <= '0;
      end
    end else begin
      vpipe_r[0] <= rd_exec_s;
      if (rd_exec_s) begin
        dpipe_r[0] <= mem_r[head_idx_s];
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        vpipe_r[i] <= vpipe_r[i-1];
        dpipe_r[i] <= dpipe_r[i-1];
      end
      if (vpipe_r[RD_LATENCY-1]) begin
        rd_cnt_r <= rd_cnt_r + 32'd1;
      end
    end
  end

  // Calibration timer, sticky error flag and write completion count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cal_cnt_r    <= '0;
      calib_done_r <= 1'b0;
      err_cmd_r    <= 1'b0;
      wr_cnt_r     <= 32'd0;
    end else begin
      if (!calib_done_r) begin
        if (cal_cnt_r == CAL_W'(CALIB_CYC - 1)) begin
          calib_done_r <= 1'b1;
        end else begin
          cal_cnt_r <= cal_cnt_r + CAL_W'(1'b1);
        end
      end
      if (ill_exec_s || (wdf_push_s && !app_wdf_end)) begin
        err_cmd_r <= 1'b1;
      end
      if (mem_we_s) begin
        wr_cnt_r <= wr_cnt_r + 32'd1;
      end
    end
  end

  assign calib_done        = calib_done_r;
  assign err_cmd           = err_cmd_r;
  assign wr_done_cnt       = wr_cnt_r;
  assign rd_done_cnt       = rd_cnt_r;
  assign app_rd_data       = dpipe_r[RD_LATENCY-1];
  assign app_rd_data_valid = vpipe_r[RD_LATENCY-1];
  assign app_rd_data_end   = vpipe_r[RD_LATENCY-1];

endmodule
